dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the memory-stage load/store interface in the pipelined RV32 core.
- Accepts one request per handshake: address from ALU result, store data, write enable, funct3.
- Performs the byte/half/word access on an internal byte-enabled RAM after a fixed latency, then returns extended load data.
- Drives a stall to the hazard unit while an access is outstanding.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- LATENCY, 2, cycles from accept to response; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  memory stage presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  WIDTH  byte address (ALU result).
- req_wdata  in  WIDTH  store data, right-aligned.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WIDTH  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access flag, valid with rsp_valid.
- stall  out  1  combinational: req_valid & ~rsp_valid.

Behaviour:
- Reset (rst low at an edge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready reads 0 while rst is low. RAM contents are not reset.
- FSM IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid, latch addr, wdata, we and funct3, load counter with LATENCY-1, and go to BUSY. If LATENCY=1, go directly to RESP.
  - BUSY: decrement counter; at 0 go to RESP.
  - RESP: for exactly one cycle, rsp_valid=1 and rsp_rdata/rsp_err are driven. The RAM write commits on this edge. Then return to IDLE.
- Latency: accept at edge T gives rsp_valid high in cycle T+LATENCY.
- Throughput: at most one access per LATENCY+1 cycles. A new accept is possible in the cycle after RESP.
- req_valid held high during BUSY/RESP is not re-accepted. Only the latched copy is used, so input changes after accept are ignored.
- Addressing: byte-addressed, little-endian. Word index = addr[$clog2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Loads:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend half addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Other codes are treated as LW.
- Stores:
  - 000 SB: lane = addr[1:0], data = wdata[7:0].
  - 001 SH: lanes 2*addr[1]+{0,1}, data = wdata[15:0].
  - 010 SW: all lanes.
  - Other codes are treated as SW.
  - Unwritten lanes are preserved.
- Misaligned access: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Handling depends on the optional feature below.
- Reset mid-operation: the pending access is abandoned, the store is not committed, no rsp_valid is produced, and the responder is in IDLE after reset.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access completes with normal timing.
  - No RAM write occurs.
  - rsp_rdata=0 and rsp_err=1 with rsp_valid.
- Undefined:
  - Low address bits are forced to the access size's alignment: addr[0] cleared for halfwords, addr[1:0] cleared for words.
  - rsp_err is tied 0.

Decomposition:
- Package dmem_pkg holds:
  - funct3 enum: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state enum.
  - Function mapping funct3 + addr[1:0] to a 4-bit byte enable.
  - Function extracting and extending load data.
- Sub-module dmem_ram: single-port synchronous RAM, DEPTH x 32, 4-bit byte write enable, registered read. The FSM starts the read one cycle before RESP.

Test Plan:
- Reset: rst low for 2 cycles with req_valid=1 -> rsp_valid=0, rsp_rdata=0, req_ready=0 during reset. req_ready=1 the first cycle after release.
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2):
  - Each access: rsp_valid exactly at T+2; stall high at T and T+1 and low at T+2.
  - LW returns rsp_rdata=0xDEADBEEF.
- SB 0x80 @0x13, then:
  - LW @0x10 -> 0x80ADBEEF.
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
- Halfword: LH @0x12 -> 0xFFFF80AD; LHU @0x12 -> 0x000080AD. Address 0x10+DEPTH*4 aliases to 0x10.
- LW @0x11:
  - With DMEM_MISALIGN_TRAP_EN: rsp_err=1, rdata=0; a later SW @0x11 leaves word 0x10 unchanged.
  - Without: returns the word at 0x10, rsp_err=0.
- SW 0x12345678 @0x20 accepted, rst low at T+1:
  - No rsp_valid is produced.
  - A later LW @0x20 returns the prior contents.
  - req_valid held high through BUSY yields exactly one response.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the memory-stage load/store responder.
// Covers access sizing, byte enables, store lane replication and load extension.
package dmem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // 0 = byte, 1 = half, 2 = word; unlisted codes fall back to word
    function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
        logic [1:0] sz;
        if (we) begin
            case (store_f3_e'(f3))
                SB:      sz = 2'd0;
                SH:      sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end else begin
            case (load_f3_e'(f3))
                LB, LBU: sz = 2'd0;
                LH, LHU: sz = 2'd1;
                default: sz = 2'd2;
            endcase
        end
        return sz;
    endfunction

    function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] sz;
        sz = access_size(we, f3);
        return ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a != 2'b00));
    endfunction

    function automatic logic [1:0] align_lo(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] r;
        case (access_size(we, f3))
            2'd0:    r = a;
            2'd1:    r = {a[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (store_f3_e'(f3))
            SB:      be = 4'b0001 << a;
            SH:      be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] d;
        case (store_f3_e'(f3))
            SB:      d = {4{wd[7:0]}};
            SH:      d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] d;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (load_f3_e'(f3))
            LB:      d = {{24{b[7]}}, b};
            LH:      d = {{16{h[15]}}, h};
            LBU:     d = {24'd0, b};
            LHU:     d = {16'd0, h};
            default: d = word;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes and read-before-write registered read port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: fixed-latency access to an internal byte-enabled RAM.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             stall
);

    localparam int AW = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_e           state;
    logic [3:0]       cnt;
    logic [AW-1:0]    widx_r;
    logic [1:0]       lo_r;
    logic [WIDTH-1:0] wdata_r;
    logic             we_r;
    logic [2:0]       f3_r;
    logic             mis_r;

    logic             mis_s;
    logic [1:0]       lo_s;
    logic [AW-1:0]    ram_addr_s;
    logic [3:0]       ram_be_s;
    logic [WIDTH-1:0] ram_q_s;

    assign mis_s      = TRAP && misaligned(req_we, req_funct3, req_addr[1:0]);
    assign lo_s       = TRAP ? req_addr[1:0] : align_lo(req_we, req_funct3, req_addr[1:0]);
    // Reads the incoming address while idle so LATENCY=1 still has data in RESP
    assign ram_addr_s = (state == ST_IDLE) ? req_addr[AW+1:2] : widx_r;
    assign req_ready  = (state == ST_IDLE) && rst;
    assign stall      = req_valid & ~rsp_valid;

    // Store commit: only in RESP, never for trapped accesses or while reset is asserted
    always_comb begin
        ram_be_s = 4'b0000;
        if ((state == ST_RESP) && we_r && !mis_r && rst) begin
            ram_be_s = byte_en(f3_r, lo_r);
        end else begin
            ram_be_s = 4'b0000;
        end
    end

    // Load data formatting from the registered RAM output
    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid && !we_r && !mis_r) begin
            rsp_rdata = load_extend(f3_r, lo_r, ram_q_s);
        end else begin
            rsp_rdata = '0;
        end
    end

    // Request FSM with latched request and registered response flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        widx_r  <= req_addr[AW+1:2];
                        lo_r    <= lo_s;
                        wdata_r <= req_wdata;
                        we_r    <= req_we;
                        f3_r    <= req_funct3;
                        mis_r   <= mis_s;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= mis_s;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= mis_r;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .be    (ram_be_s),
        .addr  (ram_addr_s),
        .wdata (store_data(f3_r, wdata_r)),
        .rdata (ram_q_s)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan items plus randomized accesses
// against a byte-array reference model. Honors DMEM_MISALIGN_TRAP_EN like the design.
module tb_dmem_responder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int BYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             stall;

    logic [7:0] mem_m [0:BYTES-1];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .stall      (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, size from funct3, modulo-wrapped address
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [2:0] f3, output logic [31:0] ed, output logic ee);
        int unsigned sz;
        int unsigned base;
        logic [31:0] v;
        if (we) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        ed = 32'd0;
        ee = 1'b0;
        if (TRAP && ((a % sz) != 0)) begin
            ee = 1'b1;
            return;
        end
        base = ((a % BYTES) / sz) * sz;
        if (we) begin
            for (int i = 0; i < int'(sz); i++) mem_m[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(sz); i++) v = v | (32'(mem_m[base + i]) << (8 * i));
            if ((f3 == 3'd0 || f3 == 3'd1) && sz < 4 && v[8*sz-1])
                v = v | (32'hFFFF_FFFF << (8 * sz));
            ed = v;
        end
    endtask

    // Starts and ends at a negedge; holds req_valid through BUSY and scrambles inputs after accept
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic [2:0] f3);
        logic [31:0] ed;
        logic        ee;
        int          cyc;
        model(a, wd, we, f3, ed, ee);
        req_addr = a; req_wdata = wd; req_we = we; req_funct3 = f3; req_valid = 1'b1;
        #1;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        check("stall_accept", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_addr = $urandom; req_wdata = $urandom; req_we = $urandom; req_funct3 = 3'($urandom);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            check("stall_busy", {31'd0, stall}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, LAT);
        check("stall_rsp", {31'd0, stall}, 32'd0);
        check("rdata", rsp_rdata, ed);
        check("err", {31'd0, rsp_err}, {31'd0, ee});
        req_valid = 1'b0;
        @(negedge clk);
        check("single_pulse", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_wdata = 32'd0;
        req_we = 1'b1; req_funct3 = 3'b010;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_rdata", rsp_rdata, 32'd0);
            check("rst_ready", {31'd0, req_ready}, 32'd0);
        end
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int w = 0; w < 16; w++) do_access(32'(w * 4), $urandom, 1'b1, 3'b010);

        do_access(32'h10, 32'hDEADBEEF, 1'b1, 3'b010);
        do_access(32'h10, 32'd0, 1'b0, 3'b010);
        do_access(32'h13, 32'h0000_0080, 1'b1, 3'b000);
        do_access(32'h10, 32'd0, 1'b0, 3'b010);
        do_access(32'h13, 32'd0, 1'b0, 3'b000);
        do_access(32'h13, 32'd0, 1'b0, 3'b100);
        do_access(32'h12, 32'd0, 1'b0, 3'b001);
        do_access(32'h12, 32'd0, 1'b0, 3'b101);
        do_access(32'h10 + BYTES, 32'd0, 1'b0, 3'b010);
        do_access(32'h11, 32'd0, 1'b0, 3'b010);
        do_access(32'h11, 32'h5555_AAAA, 1'b1, 3'b010);
        do_access(32'h10, 32'd0, 1'b0, 3'b010);

        // Store abandoned by reset one cycle after accept
        req_addr = 32'h20; req_wdata = 32'h12345678; req_we = 1'b1; req_funct3 = 3'b010;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        do_access(32'h20, 32'd0, 1'b0, 3'b010);

        for (int i = 0; i < 200; i++) begin
            a = ($urandom << 12) | 32'($urandom_range(0, 63));
            do_access(a, $urandom, 1'($urandom), 3'($urandom));
        end
        for (int w = 0; w < 16; w++) do_access(32'(w * 4), 32'd0, 1'b0, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
